pipelined_addition_unit: RTL and testbench
==========================================

Name: pipelined_addition_unit

Overview:
- Parametrised, pipelined successor to the combinational ripple adder.
- Splits an ADDER_WIDTH-bit addition into STAGES equal chunks and adds one chunk per clock. The chunk carry is registered between stages, so clock frequency no longer degrades with width.
- Valid/ready handshake on input and output, full throughput (one result per cycle), backpressure supported.
- Sits between operand producers (register file, DSP datapath) and any consumer that can stall.

Parameters:
- ADDER_WIDTH, 32, operand/sum width in bits; must be an exact multiple of STAGES.
- STAGES, 4, number of pipeline stages, which equals latency in cycles; 1 <= STAGES <= ADDER_WIDTH.
- CHUNK (localparam), ADDER_WIDTH/STAGES, bits added per stage.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  ADDER_WIDTH  operand A.
- b  input  ADDER_WIDTH  operand B.
- carry_in  input  1  carry into bit 0.
- sub  input  1  subtract mode; present only when ADDER_SUB_EN is defined.
- out_valid  output  1  sum/carry_out valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  ADDER_WIDTH  result.
- carry_out  output  1  carry out of the MSB.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n is sampled on the rising edge of clk and is active-low.
  - While rst_n=0, all stage valid bits, out_valid, sum and carry_out are cleared to 0 on the next edge.
- Stage contents:
  - Stage k (k=0..STAGES-1) holds:
    - the computed sum bits [k*CHUNK +: CHUNK] plus all lower bits already computed;
    - the chunk carry out of the chunk it just added;
    - the not-yet-added upper operand bits;
    - a valid bit.
  - Stage 0 adds a[CHUNK-1:0] + b[CHUNK-1:0] + carry_in.
  - Stage k adds the next chunk + the registered carry from stage k-1.
- Arithmetic:
  - Final result: {carry_out, sum} == a + b + carry_in, modulo 2^(ADDER_WIDTH+1).
  - The result is bit-exact with the combinational adder for every input.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 when there is no stall. It is visible in the cycle following the STAGES-th edge that includes acceptance.
- Stall and backpressure:
  - advance = !out_valid | out_ready.
  - The whole pipeline shifts only when advance=1; it is a global stall.
  - in_ready = advance (combinational). A beat transfers when in_valid & in_ready.
  - If in_valid=0 on an advance, a bubble (valid=0) enters stage 0.
  - Bubbles are not compacted.
- Output holding: while out_valid=1 and out_ready=0, sum/carry_out/out_valid stay stable and no stage changes.
- Ordering: results leave in acceptance order; no beat is dropped or duplicated.
- Boundaries:
  - STAGES=1 gives a single registered adder with latency 1.
  - Full-width carry ripple (e.g. all-ones + 1) must propagate correctly through every stage register.
  - Simultaneous output pop and input push on a full pipeline is allowed, for full throughput.
- Reset mid-operation flushes every in-flight beat. Nothing already accepted emerges after reset.
- Operand handling: a, b and carry_in are sampled only on the accepting edge. Later changes do not affect in-flight beats.

Optional Feature:
- Macro: ADDER_SUB_EN.
- When defined:
  - The sub port exists.
  - When sub=1, the beat computes a + ~b + 1 (= a - b) and carry_in is ignored.
  - carry_out=1 means no borrow (a >= b unsigned).
  - sub travels with the beat; per-beat mixing of add and sub is allowed.
- When undefined: the sub port is absent and behaviour is add-only as above.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, sum=0, carry_out=0 throughout. The first valid output appears only for beats accepted after release.
- Full carry ripple (W=32, S=4): a=0xFFFFFFFF, b=0x00000001, carry_in=0 -> after 4 cycles sum=0x00000000, carry_out=1. Repeat with a=0x7FFFFFFF, b=0, carry_in=1 -> sum=0x80000000, carry_out=0.
- Throughput and order: 8 back-to-back beats with a=i, b=0x10*i, out_ready=1 -> out_valid on 8 consecutive cycles starting at latency 4, sums 0x11*i in order, in_ready stays 1.
- Backpressure: fill the pipeline, drop out_ready for 3 cycles:
  - in_ready=0 for those cycles;
  - sum held stable;
  - after release, all beats emerge once each, in order.
- Mid-flight reset: accept 3 beats, assert rst_n=0 for 1 cycle -> out_valid=0 next cycle, and none of the 3 results ever appear.
- ADDER_SUB_EN defined:
  - a=5, b=7, sub=1 -> sum=0xFFFFFFFE, carry_out=0.
  - a=7, b=5, sub=1 -> sum=0x00000002, carry_out=1.
  - Interleaved with add beats, each result is correct.

Source files
------------

// File: rtl/pipelined_addition_unit_if.sv
// rtl/pipelined_addition_unit_if.sv - operand/result handshake bundle for pipelined_addition_unit
//
// Signals:
//   in_valid/in_ready      operand beat handshake (producer -> adder)
//   a, b, carry_in         operands, sampled on the accepting edge
//   sub                    subtract select (only when ADDER_SUB_EN is defined)
//   out_valid/out_ready    result handshake (adder -> consumer)
//   sum, carry_out         result
// Modports: master = producer/consumer side, slave = adder side.
interface pipelined_addition_unit_if #(
    parameter int ADDER_WIDTH = 32
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
    logic                   carry_in;
`ifdef ADDER_SUB_EN
    logic                   sub;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDER_WIDTH-1:0] sum;
    logic                   carry_out;

    modport master (
        output in_valid, a, b, carry_in, out_ready,
`ifdef ADDER_SUB_EN
        output sub,
`endif
        input  in_ready, out_valid, sum, carry_out
    );

    modport slave (
        input  in_valid, a, b, carry_in, out_ready,
`ifdef ADDER_SUB_EN
        input  sub,
`endif
        output in_ready, out_valid, sum, carry_out
    );
endinterface

// File: rtl/pipelined_addition_unit.sv
// rtl/pipelined_addition_unit.sv - chunked, pipelined ADDER_WIDTH-bit adder with valid/ready
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    pipelined_addition_unit_if.slave (in_valid/in_ready/a/b/carry_in[/sub],
//          out_valid/out_ready/sum/carry_out)
// Parameters: ADDER_WIDTH (multiple of STAGES), STAGES (= latency in cycles).
// Optional: define ADDER_SUB_EN to add the per-beat subtract port (a - b).
module pipelined_addition_unit #(
    parameter int ADDER_WIDTH = 32,
    parameter int STAGES      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipelined_addition_unit_if.slave    bus
);
    localparam int CHUNK = ADDER_WIDTH / STAGES;

    if (STAGES < 1 || STAGES > ADDER_WIDTH || (ADDER_WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_addition_unit: ADDER_WIDTH must be a multiple of STAGES");
    end

    // Global stall: the whole pipe moves together, so a bubble never gets squeezed out.
    logic advance;
    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    // Subtraction is folded into the operands at entry (invert b, force carry 1), so
    // the beat's mode is carried implicitly by the stored b and carry.
    logic [ADDER_WIDTH-1:0] in_b;
    logic                   in_c;
`ifdef ADDER_SUB_EN
    assign in_b = bus.sub ? ~bus.b : bus.b;
    assign in_c = bus.sub ? 1'b1   : bus.carry_in;
`else
    assign in_b = bus.b;
    assign in_c = bus.carry_in;
`endif

    // Stage registers. a_q/b_q keep the full operands; each stage only reads its chunk.
    logic                   valid_q [STAGES];
    logic [ADDER_WIDTH-1:0] sum_q   [STAGES];
    logic [ADDER_WIDTH-1:0] a_q     [STAGES];
    logic [ADDER_WIDTH-1:0] b_q     [STAGES];
    logic                   carry_q [STAGES];

    // Per-stage inputs: stage 0 reads the bus, stage k reads stage k-1.
    logic                   src_v   [STAGES];
    logic [ADDER_WIDTH-1:0] src_a   [STAGES];
    logic [ADDER_WIDTH-1:0] src_b   [STAGES];
    logic [ADDER_WIDTH-1:0] src_sum [STAGES];
    logic                   src_c   [STAGES];
    logic [CHUNK:0]         chunk   [STAGES];
    logic [ADDER_WIDTH-1:0] nxt_sum [STAGES];

    always_comb begin
        src_v[0]   = bus.in_valid;
        src_a[0]   = bus.a;
        src_b[0]   = in_b;
        src_sum[0] = '0;
        src_c[0]   = in_c;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]   = valid_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_c[k]   = carry_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            chunk[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                     + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, src_c[k]};
            nxt_sum[k] = src_sum[k];
            nxt_sum[k][k*CHUNK +: CHUNK] = chunk[k][CHUNK-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                carry_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= src_v[k];
                sum_q[k]   <= nxt_sum[k];
                a_q[k]     <= src_a[k];
                b_q[k]     <= src_b[k];
                carry_q[k] <= chunk[k][CHUNK];
            end
        end
    end

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = sum_q[STAGES-1];
    assign bus.carry_out = carry_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_addition_unit.sv
// tb/tb_pipelined_addition_unit.sv - directed self-checking bench for pipelined_addition_unit
module tb_pipelined_addition_unit;
    localparam int W = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pipelined_addition_unit_if #(.ADDER_WIDTH(W)) ifc ();
    pipelined_addition_unit_if #(.ADDER_WIDTH(8)) ifc1 ();

    pipelined_addition_unit #(.ADDER_WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    pipelined_addition_unit #(.ADDER_WIDTH(8), .STAGES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sub(input logic s);
`ifdef ADDER_SUB_EN
        ifc.sub = s;
`else
        if (s) $display("note: sub requested without ADDER_SUB_EN");
`endif
    endtask

    // Push one beat into an empty pipe and check it emerges exactly S edges later.
    task automatic send_and_check(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                                  input logic vc, input logic vs,
                                  input logic [W-1:0] exp_sum, input logic exp_co);
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.a = va; ifc.b = vb; ifc.carry_in = vc;
        set_sub(vs);
        #1;
        tests++;
        if (ifc.in_ready !== 1'b1) begin
            fails++; $display("FAIL %s in_ready: got %b expected 1", name, ifc.in_ready);
        end
        tick();
        ifc.in_valid = 1'b0;
        ifc.a = '1; ifc.b = '1; ifc.carry_in = 1'b1;   // later changes must not leak in
        set_sub(1'b0);
        for (int i = 1; i <= S; i++) begin
            if (i > 1) tick();
            tests++;
            if (i < S) begin
                if (ifc.out_valid !== 1'b0) begin
                    fails++; $display("FAIL %s early out_valid at edge %0d: got %b expected 0", name, i, ifc.out_valid);
                end
            end else if (ifc.out_valid !== 1'b1 || ifc.sum !== exp_sum || ifc.carry_out !== exp_co) begin
                fails++;
                $display("FAIL %s result: got v=%b sum=%h co=%b expected v=1 sum=%h co=%b",
                         name, ifc.out_valid, ifc.sum, ifc.carry_out, exp_sum, exp_co);
            end
        end
        tick();
        tests++;
        if (ifc.out_valid !== 1'b0) begin
            fails++; $display("FAIL %s duplicate: got out_valid=%b expected 0", name, ifc.out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.in_valid = 1'b1; ifc.a = 32'h1234; ifc.b = 32'h1; ifc.carry_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (ifc.out_valid !== 1'b0 || ifc.sum !== '0 || ifc.carry_out !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: got v=%b sum=%h co=%b expected 0/0/0", ifc.out_valid, ifc.sum, ifc.carry_out);
            end
        end
        ifc.in_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (ifc.out_valid !== 1'b0) begin
                fails++; $display("FAIL reset_leak: got out_valid=%b expected 0", ifc.out_valid);
            end
        end
    endtask

    task automatic test_carry_ripple();
        send_and_check("ripple_ones", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        send_and_check("ripple_cin",  32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0);
        send_and_check("ripple_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        send_and_check("ripple_mid",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n_out = 0;
        int first = -1;
        int last  = -1;
        ifc.out_ready = 1'b1; ifc.carry_in = 1'b0;
        set_sub(1'b0);
        for (int t = 0; t < 16; t++) begin
            ifc.in_valid = (t < 8);
            ifc.a = t; ifc.b = 32'h10 * t;
            #1;
            if (t < 8) begin
                tests++;
                if (ifc.in_ready !== 1'b1) begin
                    fails++; $display("FAIL b2b in_ready t=%0d: got %b expected 1", t, ifc.in_ready);
                end
            end
            if (ifc.out_valid === 1'b1) begin
                tests++;
                if (ifc.sum !== 32'h11 * n_out || ifc.carry_out !== 1'b0) begin
                    fails++; $display("FAIL b2b sum #%0d: got %h expected %h", n_out, ifc.sum, 32'h11 * n_out);
                end
                if (first < 0) first = t;
                last = t;
                n_out++;
            end
            tick();
        end
        ifc.in_valid = 1'b0;
        tests++;
        if (n_out != 8 || first != S || last - first != 7) begin
            fails++; $display("FAIL b2b timing: got n=%0d first=%0d last=%0d expected n=8 first=%0d last=%0d",
                              n_out, first, last, S, S + 7);
        end
    endtask

    task automatic test_backpressure();
        int n_in = 0;
        int n_out = 0;
        int stalls = 0;
        logic prev_stall = 1'b0;
        logic [W-1:0] prev_sum = '0;
        ifc.carry_in = 1'b0;
        set_sub(1'b0);
        for (int t = 0; t < 40; t++) begin
            ifc.out_ready = !(t >= 6 && t <= 8);
            ifc.in_valid  = (n_in < 12);
            ifc.a = 32'h1000 + n_in; ifc.b = 32'h20 * n_in;
            #1;
            if (ifc.out_valid === 1'b1) begin
                tests++;
                if (n_out >= 12) begin
                    fails++; $display("FAIL bp extra output: got sum=%h expected none", ifc.sum);
                end else if (ifc.sum !== 32'h1000 + 32'h21 * n_out) begin
                    fails++; $display("FAIL bp order #%0d: got %h expected %h", n_out, ifc.sum, 32'h1000 + 32'h21 * n_out);
                end
            end
            if (ifc.out_valid === 1'b1 && !ifc.out_ready) begin
                stalls++;
                tests++;
                if (ifc.in_ready !== 1'b0) begin
                    fails++; $display("FAIL bp in_ready t=%0d: got %b expected 0", t, ifc.in_ready);
                end
                if (prev_stall) begin
                    tests++;
                    if (ifc.sum !== prev_sum) begin
                        fails++; $display("FAIL bp hold: got %h expected %h", ifc.sum, prev_sum);
                    end
                end
            end
            prev_stall = ifc.out_valid && !ifc.out_ready;
            prev_sum   = ifc.sum;
            if (ifc.out_valid && ifc.out_ready) n_out++;
            if (ifc.in_valid && ifc.in_ready) n_in++;
            tick();
        end
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
        tests++;
        if (n_out != 12 || stalls != 3) begin
            fails++; $display("FAIL bp counts: got out=%0d stalls=%0d expected out=12 stalls=3", n_out, stalls);
        end
    endtask

    task automatic test_midflight_reset();
        ifc.out_ready = 1'b1; ifc.carry_in = 1'b0;
        set_sub(1'b0);
        for (int t = 0; t < 3; t++) begin
            ifc.in_valid = 1'b1; ifc.a = 32'hAAAA_0000 + t; ifc.b = 32'h0;
            tick();
        end
        ifc.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tests++;
        if (ifc.out_valid !== 1'b0 || ifc.sum !== '0) begin
            fails++; $display("FAIL midreset clear: got v=%b sum=%h expected v=0 sum=0", ifc.out_valid, ifc.sum);
        end
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            tests++;
            if (ifc.out_valid !== 1'b0) begin
                fails++; $display("FAIL midreset flush: got out_valid=1 sum=%h expected none", ifc.sum);
            end
        end
    endtask

    task automatic test_single_stage();
        ifc1.out_ready = 1'b1;
        ifc1.in_valid = 1'b1; ifc1.a = 8'hFF; ifc1.b = 8'h01; ifc1.carry_in = 1'b0;
        tick();
        ifc1.in_valid = 1'b0;
        tests++;
        if (ifc1.out_valid !== 1'b1 || ifc1.sum !== 8'h00 || ifc1.carry_out !== 1'b1) begin
            fails++; $display("FAIL s1 result: got v=%b sum=%h co=%b expected 1/00/1", ifc1.out_valid, ifc1.sum, ifc1.carry_out);
        end
        tick();
        tests++;
        if (ifc1.out_valid !== 1'b0) begin
            fails++; $display("FAIL s1 drain: got out_valid=%b expected 0", ifc1.out_valid);
        end
    endtask

`ifdef ADDER_SUB_EN
    task automatic test_sub();
        logic [W-1:0] va [4] = '{32'd10, 32'd20, 32'd0, 32'hFFFF_FFFF};
        logic [W-1:0] vb [4] = '{32'd20, 32'd10, 32'd1, 32'h0000_0001};
        logic         vs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] es [4] = '{32'd31, 32'd10, 32'hFFFF_FFFF, 32'h0};
        logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int n_out = 0;
        send_and_check("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        send_and_check("sub_noborrow", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1);
        ifc.out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            ifc.in_valid = (t < 4);
            if (t < 4) begin
                ifc.a = va[t]; ifc.b = vb[t]; ifc.sub = vs[t]; ifc.carry_in = (t == 0);
            end
            #1;
            if (ifc.out_valid === 1'b1) begin
                tests++;
                if (n_out >= 4 || ifc.sum !== es[n_out] || ifc.carry_out !== ec[n_out]) begin
                    fails++; $display("FAIL mix #%0d: got sum=%h co=%b", n_out, ifc.sum, ifc.carry_out);
                end
                n_out++;
            end
            tick();
        end
        ifc.in_valid = 1'b0; ifc.sub = 1'b0;
        tests++;
        if (n_out != 4) begin
            fails++; $display("FAIL mix count: got %0d expected 4", n_out);
        end
    endtask
`endif

    initial begin
        ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.carry_in = 1'b0; ifc.out_ready = 1'b1;
        ifc1.in_valid = 1'b0; ifc1.a = '0; ifc1.b = '0; ifc1.carry_in = 1'b0; ifc1.out_ready = 1'b1;
`ifdef ADDER_SUB_EN
        ifc.sub = 1'b0;
        ifc1.sub = 1'b0;
`endif
        test_reset();
        test_carry_ripple();
        test_back_to_back();
        test_backpressure();
        test_midflight_reset();
        test_single_stage();
`ifdef ADDER_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
